mul_float: RTL and testbench

MUL_FLOAT -- requirements
Module: mul_float

---
 rtl/mul_float.sv | 181 ++++++++++++++++++
 tb/tb_mul_float.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mul_float.sv
// rtl/mul_float.sv - multi-cycle IEEE-754 single-precision multiplier, shift-add mantissa datapath
// Fixed 27-cycle latency from start edge to done, truncating rounding, denormals flushed to zero.
module mul_float #(
  parameter int FLOAT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [FLOAT_WIDTH-1:0] a,
  input  logic [FLOAT_WIDTH-1:0] b,
  output logic [FLOAT_WIDTH-1:0] o,
  output logic                   nan,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   zero,
  output logic                   done
);

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    MULT,
    NORM,
    DONE
  } state_t;

  state_t state, state_next;

  logic [31:0]        a_r, b_r;
  logic               sign_r;
  logic signed [9:0]  exp_sum;
  logic signed [9:0]  exp_n;
  logic [22:0]        frac_n;
  logic [47:0]        mcand;
  logic [23:0]        mplier;
  logic [47:0]        acc;
  logic [4:0]         cnt;
  logic               spec_nan, spec_inf, spec_zero;

  // operand classification from the captured inputs
  logic [7:0]         ea, eb;
  logic [22:0]        fa, fb;
  logic               a_is_nan, a_is_inf, a_is_zero;
  logic               b_is_nan, b_is_inf, b_is_zero;
  logic [23:0]        ma, mb;
  logic signed [9:0]  exp_raw;

  always_comb begin
    ea        = a_r[30:23];
    eb        = b_r[30:23];
    fa        = a_r[22:0];
    fb        = b_r[22:0];
    a_is_nan  = (&ea) && (|fa);
    b_is_nan  = (&eb) && (|fb);
    a_is_inf  = (&ea) && !(|fa);
    b_is_inf  = (&eb) && !(|fb);
    a_is_zero = !(|ea);
    b_is_zero = !(|eb);
    ma        = a_is_zero ? 24'd0 : {1'b1, fa};
    mb        = b_is_zero ? 24'd0 : {1'b1, fb};
    exp_raw   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = UNPACK;
      UNPACK:  state_next = MULT;
      MULT:    if (cnt == 5'd23) state_next = NORM;
      NORM:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // final packing; special classes take precedence over the computed exponent
  logic [31:0] res_o;
  logic        res_nan, res_ovf, res_unf, res_zero;

  always_comb begin
    res_o    = 32'd0;
    res_nan  = 1'b0;
    res_ovf  = 1'b0;
    res_unf  = 1'b0;
    res_zero = 1'b0;
    if (spec_nan) begin
      res_o   = 32'h7FC0_0000;
      res_nan = 1'b1;
    end else if (spec_inf) begin
      res_o = {sign_r, 8'hFF, 23'd0};
    end else if (spec_zero) begin
      res_o    = {sign_r, 31'd0};
      res_zero = 1'b1;
    end else if (exp_n >= 10'sd255) begin
      res_o   = {sign_r, 8'hFF, 23'd0};
      res_ovf = 1'b1;
    end else if (exp_n <= 10'sd0) begin
      res_o    = {sign_r, 31'd0};
      res_unf  = 1'b1;
      res_zero = 1'b1;
    end else begin
      res_o = {sign_r, exp_n[7:0], frac_n};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r       <= '0;
      b_r       <= '0;
      sign_r    <= 1'b0;
      exp_sum   <= '0;
      exp_n     <= '0;
      frac_n    <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      spec_nan  <= 1'b0;
      spec_inf  <= 1'b0;
      spec_zero <= 1'b0;
      o         <= '0;
      nan       <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      zero      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r <= a[31:0];
            b_r <= b[31:0];
            acc <= '0;
          end
        end
        UNPACK: begin
          sign_r    <= a_r[31] ^ b_r[31];
          exp_sum   <= exp_raw;
          mcand     <= {24'd0, ma};
          mplier    <= mb;
          acc       <= '0;
          cnt       <= '0;
          spec_nan  <= a_is_nan || b_is_nan || (a_is_inf && b_is_zero) || (a_is_zero && b_is_inf);
          spec_inf  <= a_is_inf || b_is_inf;
          spec_zero <= a_is_zero || b_is_zero;
        end
        MULT: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
        end
        NORM: begin
          if (acc[47]) begin
            exp_n  <= exp_sum + 10'sd1;
            frac_n <= acc[46:24];
          end else begin
            exp_n  <= exp_sum;
            frac_n <= acc[45:23];
          end
        end
        DONE: begin
          o         <= res_o;
          nan       <= res_nan;
          overflow  <= res_ovf;
          underflow <= res_unf;
          zero      <= res_zero;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_float.sv
// tb/tb_mul_float.sv - directed vector bench for mul_float
module tb_mul_float;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] o;
  logic        nan, overflow, underflow, zero, done;

  int tests = 0;
  int fails = 0;

  mul_float #(.FLOAT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .o(o),
    .nan(nan), .overflow(overflow), .underflow(underflow), .zero(zero), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] o;
    logic [3:0]  f; // {nan, overflow, underflow, zero}
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  // start is sampled on edge 0; returns the edge index after which done was first seen
  task automatic run_op(input logic [31:0] va, input logic [31:0] vb, output int lat);
    @(negedge clk);
    a = va;
    b = vb;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  function automatic vec_t mk(input logic [31:0] va, vb, vo, input logic [3:0] vf, input string n);
    vec_t v;
    v.a = va; v.b = vb; v.o = vo; v.f = vf; v.name = n;
    return v;
  endfunction

  initial begin
    int lat;
    int ndone;

    vecs.push_back(mk(32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, "2x3"));
    vecs.push_back(mk(32'hBFC00000, 32'h40000000, 32'hC0400000, 4'b0000, "-1.5x2"));
    vecs.push_back(mk(32'h40A00000, 32'h40A00000, 32'h41C80000, 4'b0000, "5x5"));
    vecs.push_back(mk(32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, "1x1"));
    vecs.push_back(mk(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0000, "trunc"));
    vecs.push_back(mk(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b1000, "nan_in"));
    vecs.push_back(mk(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, "inf_x_0"));
    vecs.push_back(mk(32'h00000000, 32'hFF800000, 32'h7FC00000, 4'b1000, "0_x_ninf"));
    vecs.push_back(mk(32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000, "inf_x_neg2"));
    vecs.push_back(mk(32'h7F800000, 32'h7F800000, 32'h7F800000, 4'b0000, "inf_x_inf"));
    vecs.push_back(mk(32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0100, "ovf_big"));
    vecs.push_back(mk(32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0100, "ovf_e255"));
    vecs.push_back(mk(32'h7F000000, 32'h3F800000, 32'h7F000000, 4'b0000, "e254"));
    vecs.push_back(mk(32'h7F400000, 32'h3FC00000, 32'h7F800000, 4'b0100, "ovf_norm"));
    vecs.push_back(mk(32'h00800000, 32'h00800000, 32'h00000000, 4'b0011, "unf_small"));
    vecs.push_back(mk(32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, "unf_e0"));
    vecs.push_back(mk(32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000, "e1"));
    vecs.push_back(mk(32'h80000000, 32'h3F800000, 32'h80000000, 4'b0001, "nzero"));
    vecs.push_back(mk(32'h00000001, 32'h3F800000, 32'h00000000, 4'b0001, "denorm"));

    repeat (2) @(posedge clk);
    #1;
    check("reset_o", o, 32'h0);
    check("reset_flags", {27'd0, nan, overflow, underflow, zero, done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      run_op(vecs[k].a, vecs[k].b, lat);
      check({vecs[k].name, "_latency"}, lat, 32'd27);
      check({vecs[k].name, "_o"}, o, vecs[k].o);
      check({vecs[k].name, "_flags"}, {28'd0, nan, overflow, underflow, zero}, {28'd0, vecs[k].f});
      @(posedge clk);
      #1;
      check({vecs[k].name, "_done_pulse"}, {31'd0, done}, 32'd0);
      check({vecs[k].name, "_hold_o"}, o, vecs[k].o);
    end

    // start re-pulsed mid-operation with other operands must be ignored
    @(negedge clk);
    a = 32'h40000000; b = 32'h40400000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      if (i == 5) begin
        a = 32'h40A00000; b = 32'h40A00000; start = 1'b1;
      end
      @(posedge clk);
      #1;
      if (i == 5) start = 1'b0;
      if (done) begin
        ndone++;
        if (lat < 0) lat = i;
      end
    end
    check("restart_latency", lat, 32'd27);
    check("restart_done_count", ndone, 32'd1);
    check("restart_o", o, 32'h40C00000);

    // reset in the middle of an operation
    @(negedge clk);
    a = 32'h3F800000; b = 32'h40000000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_o", o, 32'h0);
    check("midrst_flags", {27'd0, nan, overflow, underflow, zero, done}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("midrst_no_done", ndone, 32'd0);
    run_op(32'h40A00000, 32'h40A00000, lat);
    check("post_rst_latency", lat, 32'd27);
    check("post_rst_o", o, 32'h41C80000);
    check("post_rst_flags", {28'd0, nan, overflow, underflow, zero}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
